mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous SRAM (1-cycle read latency) between the
//  MIPS instruction-fetch port and data-access port. Sits between the mips core
//  and a unified ram. Data has priority; instruction fetch is stalled on
//  conflict, with a starvation limit. Routes each read response back to its owner
//  and holds each port's last read data stable while that port is stalled.
// PARAMETERS
//  ADDR_W      32  address width, byte address, passed through unchanged
//  DATA_W      32  data width; byte-enable width is DATA_W/8
//  STARVE_MAX  4   consecutive data grants allowed while inst_req is pending
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        synchronous reset, active-high
//  inst_req     in   1        fetch request; hold req/addr stable until inst_gnt
//  inst_addr    in   ADDR_W   fetch address
//  inst_gnt     out  1        fetch issued to ram this cycle (combinational)
//  inst_stall   out  1        inst_req & ~inst_gnt
//  inst_rvalid  out  1        fetch data valid; exactly 1 cycle after inst_gnt
//  inst_rdata   out  DATA_W   fetch data; holds last value when ~inst_rvalid
//  data_req     in   1        load/store request; hold fields stable until data_gnt
//  data_wen     in   DATA_W/8 byte write enables; 0 = load
//  data_addr    in   ADDR_W   data address
//  data_wdata   in   DATA_W   store data
//  data_gnt     out  1        data access issued to ram this cycle (combinational)
//  data_rvalid  out  1        load data valid; 1 cycle after a load data_gnt
//  data_rdata   out  DATA_W   load data; holds last value when ~data_rvalid
//  ram_en       out  1        ram enable = inst_gnt | data_gnt
//  ram_wen      out  DATA_W/8 data_wen when data_gnt, else 0
//  ram_addr     out  ADDR_W   address of granted requester, else 0
//  ram_wdata    out  DATA_W   data_wdata when data_gnt, else 0
//  ram_rdata    in   DATA_W   ram read data, valid 1 cycle after ram_en
// BEHAVIOUR
//  - Grant (combinational, at most one per cycle):
//    data_req & ~(inst_req & starve_cnt==STARVE_MAX) -> data_gnt;
//    else inst_req -> inst_gnt; else no grant.
//  - starve_cnt (width clog2(STARVE_MAX+1)): +1 on data_gnt while inst_req is
//    high; cleared on inst_gnt or when inst_req is low; saturates at STARVE_MAX.
//  - Response FSM, state = owner of last cycle's read:
//    S_IDLE: nothing pending; S_RSP_I: fetch issued; S_RSP_D: load issued.
//    Next state each cycle: inst_gnt -> S_RSP_I; data_gnt & data_wen==0 ->
//    S_RSP_D; otherwise S_IDLE (stores produce no response). Back-to-back
//    issue is allowed; every state can go to every state.
//  - inst_rvalid = (state==S_RSP_I); data_rvalid = (state==S_RSP_D).
//  - *_rdata = ram_rdata when own rvalid, else own hold register; hold register
//    captures ram_rdata on own rvalid.
//  - Latency: grant to rvalid = 1 cycle; no combinational req->rdata path.
//  - Reset values: state S_IDLE, starve_cnt 0, hold registers 0; thus
//    inst_rvalid=data_rvalid=0, *_rdata=0 the cycle after rst is sampled.
//    Grant/ram_* outputs follow inputs combinationally even during rst, but
//    ram_en, ram_wen and both grants are forced 0 while rst=1.
//  - Reset mid-operation: a pending read response is dropped (no rvalid).
//  - Simultaneous req with starve_cnt<STARVE_MAX: data wins, inst_stall=1.
//  - Same address, fetch and store: order set by grant; no forwarding.
// STRUCTURE
//  - Package mem_arb_pkg: response-state localparams S_IDLE/S_RSP_I/S_RSP_D
//    (2 bits) and the starve_cnt width function.
//  - Sub-module mem_arb_hold: rdata hold register + bypass mux, instantiated
//    once per port.
//  - Grant logic, starve counter, FSM inline in mem_port_arbiter.
// TESTING
//  1 rst=1 for 2 cycles with both reqs high -> ram_en=0, no gnt; after release
//    rvalids=0, rdata=0.
//  2 inst_req only, addr 0x00,0x04,0x08 back-to-back -> inst_gnt every cycle,
//    inst_rvalid 1 cycle later, rdata = ram model words in order.
//  3 both reqs, data load addr 0x100 -> data_gnt, inst_stall=1; next cycle
//    data_rvalid=1, inst_rdata unchanged from previous value.
//  4 data_req held with 6 loads, inst_req held (STARVE_MAX=4) -> 4 data grants,
//    then 1 inst grant, then data resumes; starve_cnt back to 0.
//  5 store data_wen=4'b0011 addr 0x200 wdata 0xDEADBEEF -> ram_wen=0011,
//    no data_rvalid next cycle; subsequent load of 0x200 returns 0x0000BEEF
//    into a zeroed ram.
//  6 rst asserted the cycle after a fetch grant -> inst_rvalid stays 0,
//    inst_rdata = 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the instruction/data SRAM port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RSP_I = 2'd1,
    S_RSP_D = 2'd2
  } rsp_state_e;

  function automatic int unsigned starve_cnt_w(input int unsigned starve_max);
    return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_hold.sv
// Per-port read-data hold register: bypasses live ram data on rvalid,
// otherwise presents the last data delivered to this port.
module mem_arb_hold #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  always_comb begin
    hold_d = hold_q;
    if (rvalid) hold_d = ram_rdata;
    rdata = rvalid ? ram_rdata : hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data
// access; data has priority, bounded by a fetch starvation limit.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_stall,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int unsigned CNT_W = starve_cnt_w(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  rsp_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             data_win;
  logic             inst_win;

  // Arbitration and ram steering; address/wdata pass through ungated by reset.
  always_comb begin
    data_win   = data_req & ~(inst_req & (starve_cnt_q == CNT_MAX));
    inst_win   = inst_req & ~data_win;
    data_gnt   = data_win & ~rst;
    inst_gnt   = inst_win & ~rst;
    inst_stall = inst_req & ~inst_gnt;
    ram_en     = inst_gnt | data_gnt;
    ram_wen    = data_gnt ? data_wen : '0;
    ram_addr   = data_win ? data_addr : (inst_win ? inst_addr : '0);
    ram_wdata  = data_win ? data_wdata : '0;
  end

  // Starvation counter and response-owner FSM.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    state_d      = S_IDLE;
    if (inst_gnt || !inst_req) begin
      starve_cnt_d = '0;
    end else if (data_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
    if (inst_gnt) begin
      state_d = S_RSP_I;
    end else if (data_gnt && (data_wen == '0)) begin
      state_d = S_RSP_D;
    end
    // A response due in a reset cycle is dropped.
    inst_rvalid = (state_q == S_RSP_I) & ~rst;
    data_rvalid = (state_q == S_RSP_D) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_arb_hold #(.DATA_W(DATA_W)) u_inst_hold (
    .clk       (clk),
    .rst       (rst),
    .rvalid    (inst_rvalid),
    .ram_rdata (ram_rdata),
    .rdata     (inst_rdata)
  );

  mem_arb_hold #(.DATA_W(DATA_W)) u_data_hold (
    .clk       (clk),
    .rst       (rst),
    .rvalid    (data_rvalid),
    .ram_rdata (ram_rdata),
    .rdata     (data_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, starvation sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_gnt, inst_stall, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0;
  logic [3:0]  data_wen = '0;
  logic [31:0] data_addr = '0;
  logic [31:0] data_wdata = '0;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_stall(inst_stall), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .ram_en(ram_en), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port ram, 1-cycle read latency.
  logic [31:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen != 4'b0000) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) ram_mem[ram_addr[11:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram_mem[ram_addr[11:2]];
      end
    end
  end

  function automatic logic [31:0] init_word(input int i);
    return (i == 'h80) ? 32'h0 : (32'hC0DE0000 | 32'(i));
  endfunction

  // Reference model: shadow memory plus one outstanding response per port.
  logic [31:0] ref_mem [0:1023];
  int          starve;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_dat, pend_d_dat, hold_i, hold_d;
  bit          last_ig, last_dg;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic ireq, input logic [31:0] iaddr,
                      input logic dreq, input logic [3:0] dwen,
                      input logic [31:0] daddr, input logic [31:0] dwdata);
    bit exp_dg, exp_ig, exp_ir, exp_dr;
    logic [31:0] exp_ird, exp_drd;
    @(negedge clk);
    rst = r; inst_req = ireq; inst_addr = iaddr;
    data_req = dreq; data_wen = dwen; data_addr = daddr; data_wdata = dwdata;
    #1;
    exp_dg  = !r && dreq && !(ireq && starve == STARVE_MAX);
    exp_ig  = !r && ireq && !exp_dg;
    exp_ir  = !r && pend_i;
    exp_dr  = !r && pend_d;
    exp_ird = exp_ir ? pend_i_dat : hold_i;
    exp_drd = exp_dr ? pend_d_dat : hold_d;
    chk("inst_gnt", 32'(inst_gnt), 32'(exp_ig));
    chk("data_gnt", 32'(data_gnt), 32'(exp_dg));
    chk("inst_stall", 32'(inst_stall), 32'(ireq && !exp_ig));
    chk("ram_en", 32'(ram_en), 32'(exp_ig || exp_dg));
    chk("ram_wen", 32'(ram_wen), exp_dg ? 32'(dwen) : 32'h0);
    chk("inst_rvalid", 32'(inst_rvalid), 32'(exp_ir));
    chk("data_rvalid", 32'(data_rvalid), 32'(exp_dr));
    if (!r) begin
      chk("ram_addr", ram_addr, exp_dg ? daddr : (exp_ig ? iaddr : 32'h0));
      chk("ram_wdata", ram_wdata, exp_dg ? dwdata : 32'h0);
      chk("inst_rdata", inst_rdata, exp_ird);
      chk("data_rdata", data_rdata, exp_drd);
    end
    last_ig = exp_ig;
    last_dg = exp_dg;
    if (r) begin
      pend_i = 0; pend_d = 0; hold_i = '0; hold_d = '0; starve = 0;
    end else begin
      if (exp_ir) hold_i = pend_i_dat;
      if (exp_dr) hold_d = pend_d_dat;
      pend_i = exp_ig;
      if (exp_ig) pend_i_dat = ref_mem[iaddr[11:2]];
      pend_d = exp_dg && (dwen == 4'b0000);
      if (pend_d) pend_d_dat = ref_mem[daddr[11:2]];
      if (exp_dg && dwen != 4'b0000)
        for (int b = 0; b < 4; b++)
          if (dwen[b]) ref_mem[daddr[11:2]][8*b +: 8] = dwdata[8*b +: 8];
      if (exp_ig || !ireq) starve = 0;
      else if (exp_dg && starve < STARVE_MAX) starve++;
    end
  endtask

  typedef struct {
    logic r, ireq; logic [31:0] iaddr;
    logic dreq; logic [3:0] dwen; logic [31:0] daddr, dwdata;
    logic ig, dg, ir, dr, chk_rd; logic [31:0] ird, drd;
  } vec_t;

  function automatic vec_t mkv(input logic r, ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [3:0] dwen,
                               input logic [31:0] daddr, dwdata,
                               input logic ig, dg, ir, dr, chk_rd,
                               input logic [31:0] ird, drd);
    vec_t v;
    v.r = r; v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwen = dwen;
    v.daddr = daddr; v.dwdata = dwdata; v.ig = ig; v.dg = dg; v.ir = ir;
    v.dr = dr; v.chk_rd = chk_rd; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  vec_t vt [24];

  initial begin
    int dcnt;
    bit got_ig;
    logic [31:0] da;
    bit cir, cdr;
    logic [31:0] cia, cda, cdw;
    logic [3:0] cwe;
    logic cr;

    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    starve = 0; pend_i = 0; pend_d = 0; hold_i = '0; hold_d = '0;
    pend_i_dat = '0; pend_d_dat = '0;

    //          r ireq iaddr     dreq wen   daddr     dwdata        ig dg ir dr ck ird           drd
    vt[0]  = mkv(1, 1, 32'h00,  1, 4'h0, 32'h100, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0);
    vt[1]  = mkv(1, 1, 32'h00,  1, 4'h0, 32'h100, 32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0);
    vt[2]  = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 0, 1, 32'h0,        32'h0);
    vt[3]  = mkv(0, 1, 32'h00,  0, 4'h0, 32'h0,   32'h0,          1, 0, 0, 0, 1, 32'h0,        32'h0);
    vt[4]  = mkv(0, 1, 32'h04,  0, 4'h0, 32'h0,   32'h0,          1, 0, 1, 0, 1, 32'hC0DE0000, 32'h0);
    vt[5]  = mkv(0, 1, 32'h08,  0, 4'h0, 32'h0,   32'h0,          1, 0, 1, 0, 1, 32'hC0DE0001, 32'h0);
    vt[6]  = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 1, 0, 1, 32'hC0DE0002, 32'h0);
    vt[7]  = mkv(0, 1, 32'h0C,  1, 4'h0, 32'h100, 32'h0,          0, 1, 0, 0, 1, 32'hC0DE0002, 32'h0);
    vt[8]  = mkv(0, 1, 32'h0C,  0, 4'h0, 32'h0,   32'h0,          1, 0, 0, 1, 1, 32'hC0DE0002, 32'hC0DE0040);
    vt[9]  = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 1, 0, 1, 32'hC0DE0003, 32'hC0DE0040);
    vt[10] = mkv(0, 1, 32'h10,  1, 4'h0, 32'h104, 32'h0,          0, 1, 0, 0, 1, 32'hC0DE0003, 32'hC0DE0040);
    vt[11] = mkv(0, 1, 32'h10,  1, 4'h0, 32'h108, 32'h0,          0, 1, 0, 1, 1, 32'hC0DE0003, 32'hC0DE0041);
    vt[12] = mkv(0, 1, 32'h10,  1, 4'h0, 32'h10C, 32'h0,          0, 1, 0, 1, 1, 32'hC0DE0003, 32'hC0DE0042);
    vt[13] = mkv(0, 1, 32'h10,  1, 4'h0, 32'h110, 32'h0,          0, 1, 0, 1, 1, 32'hC0DE0003, 32'hC0DE0043);
    vt[14] = mkv(0, 1, 32'h10,  1, 4'h0, 32'h114, 32'h0,          1, 0, 0, 1, 1, 32'hC0DE0003, 32'hC0DE0044);
    vt[15] = mkv(0, 0, 32'h00,  1, 4'h0, 32'h114, 32'h0,          0, 1, 1, 0, 1, 32'hC0DE0004, 32'hC0DE0044);
    vt[16] = mkv(0, 0, 32'h00,  1, 4'h0, 32'h118, 32'h0,          0, 1, 0, 1, 1, 32'hC0DE0004, 32'hC0DE0045);
    vt[17] = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 1, 1, 32'hC0DE0004, 32'hC0DE0046);
    vt[18] = mkv(0, 0, 32'h00,  1, 4'h3, 32'h200, 32'hDEADBEEF,   0, 1, 0, 0, 1, 32'hC0DE0004, 32'hC0DE0046);
    vt[19] = mkv(0, 0, 32'h00,  1, 4'h0, 32'h200, 32'h0,          0, 1, 0, 0, 1, 32'hC0DE0004, 32'hC0DE0046);
    vt[20] = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 1, 1, 32'hC0DE0004, 32'h0000BEEF);
    vt[21] = mkv(0, 1, 32'h18,  0, 4'h0, 32'h0,   32'h0,          1, 0, 0, 0, 1, 32'hC0DE0004, 32'h0000BEEF);
    vt[22] = mkv(1, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 0, 0, 32'h0,        32'h0);
    vt[23] = mkv(0, 0, 32'h00,  0, 4'h0, 32'h0,   32'h0,          0, 0, 0, 0, 1, 32'h0,        32'h0);

    for (int k = 0; k < 24; k++) begin
      step(vt[k].r, vt[k].ireq, vt[k].iaddr, vt[k].dreq, vt[k].dwen, vt[k].daddr, vt[k].dwdata);
      chk($sformatf("vec%0d_inst_gnt", k), 32'(inst_gnt), 32'(vt[k].ig));
      chk($sformatf("vec%0d_data_gnt", k), 32'(data_gnt), 32'(vt[k].dg));
      chk($sformatf("vec%0d_inst_rvalid", k), 32'(inst_rvalid), 32'(vt[k].ir));
      chk($sformatf("vec%0d_data_rvalid", k), 32'(data_rvalid), 32'(vt[k].dr));
      if (vt[k].chk_rd) begin
        chk($sformatf("vec%0d_inst_rdata", k), inst_rdata, vt[k].ird);
        chk($sformatf("vec%0d_data_rdata", k), data_rdata, vt[k].drd);
      end
    end

    // Two starvation windows back to back: each must allow exactly STARVE_MAX data grants.
    da = 32'h140;
    for (int w = 0; w < 2; w++) begin
      dcnt = 0;
      got_ig = 0;
      for (int c = 0; c < 10 && !got_ig; c++) begin
        step(0, 1, 32'h40 + 32'(w) * 4, 1, 4'h0, da, 32'h0);
        if (data_gnt) begin
          dcnt++;
          da = da + 4;
        end
        if (inst_gnt) got_ig = 1;
      end
      chk($sformatf("starve_win%0d_inst_granted", w), 32'(got_ig), 32'd1);
      chk($sformatf("starve_win%0d_data_grants", w), 32'(dcnt), 32'(STARVE_MAX));
    end
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic; requests held stable until granted.
    cir = 0; cdr = 0; cia = '0; cda = '0; cdw = '0; cwe = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!cir) begin
        cir = ($urandom_range(0, 2) != 0);
        cia = 32'($urandom_range(0, 63)) << 2;
      end
      if (!cdr) begin
        cdr = ($urandom_range(0, 2) != 0);
        cda = 32'($urandom_range(0, 63)) << 2;
        cdw = $urandom;
        cwe = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      cr = ($urandom_range(0, 63) == 0);
      step(cr, cir, cia, cdr, cwe, cda, cdw);
      if (last_ig) cir = 0;
      if (last_dg) cdr = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
